// File: rtl/proc_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_gain_ctrl
// Description : ADC->DAC sample sequencer with offset correction, power-of-two
//               saturating gain and a 16-step click-free mute/gain ramp.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_gain_ctrl #(
    parameter int          CLK_DIV    = 5000,
    parameter logic [9:0]  ADC_OFFSET = 10'h181,
    parameter logic [9:0]  DAC_OFFSET = 10'h200
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [9:0]  data_in,
    input  logic [1:0]  gain_sel,
    input  logic        mute,
    output logic [9:0]  data_out,
    output logic        sample_tick,
    output logic        busy
);

    localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  c_cnt_max = CW'(CLK_DIV - 1);

    localparam logic [1:0] c_muted     = 2'd0;
    localparam logic [1:0] c_ramp_up   = 2'd1;
    localparam logic [1:0] c_run       = 2'd2;
    localparam logic [1:0] c_ramp_down = 2'd3;

    logic [CW-1:0]       r_cnt;
    logic [4:0]          r_level;
    logic [1:0]          r_gain;
    logic [1:0]          r_state;
    logic [9:0]          r_data_out;

    logic                w_tick;
    logic                w_change;
    logic signed [9:0]   w_x;
    logic signed [12:0]  w_g_wide;
    logic signed [9:0]   w_g_sat;
    logic signed [13:0]  w_prod;
    logic [9:0]          w_dout_next;

    assign w_tick   = (r_cnt == c_cnt_max);
    assign w_change = mute || (gain_sel != r_gain);

    assign w_x      = $signed(data_in - ADC_OFFSET);
    assign w_g_wide = $signed({{3{w_x[9]}}, w_x}) <<< r_gain;

    always_comb begin
        w_g_sat = w_g_wide[9:0];
        if (w_g_wide > 13'sd511)
            w_g_sat = 10'sh1FF;
        else if (w_g_wide < -13'sd512)
            w_g_sat = 10'sh200;
    end

    // Product always fits 14 bits, so the low 10 bits of the >>>4 are exact.
    assign w_prod      = $signed({{4{w_g_sat[9]}}, w_g_sat}) * $signed({9'd0, r_level});
    assign w_dout_next = 10'(w_prod >>> 4) + DAC_OFFSET;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_level    <= 5'd0;
            r_gain     <= 2'd0;
            r_state    <= c_muted;
            r_data_out <= DAC_OFFSET;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick)
                r_data_out <= w_dout_next;

            case (r_state)
                c_muted: begin
                    r_level <= 5'd0;
                    if (!mute) begin
                        r_gain  <= gain_sel;
                        r_state <= c_ramp_up;
                    end
                end
                c_ramp_up: begin
                    if (w_tick)
                        r_level <= r_level + 5'd1;
                    // An abort wins over completion; the level step still lands.
                    if (w_change)
                        r_state <= c_ramp_down;
                    else if (w_tick && r_level == 5'd15)
                        r_state <= c_run;
                end
                c_run: begin
                    r_level <= 5'd16;
                    if (w_change)
                        r_state <= c_ramp_down;
                end
                c_ramp_down: begin
                    if (r_level == 5'd0)
                        r_state <= c_muted;
                    else if (w_tick) begin
                        r_level <= r_level - 5'd1;
                        if (r_level == 5'd1)
                            r_state <= c_muted;
                    end
                end
                default: r_state <= c_muted;
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign sample_tick = w_tick;
    assign busy        = (r_state == c_ramp_up) || (r_state == c_ramp_down);

endmodule
`default_nettype wire

// File: tb/tb_proc_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_gain_ctrl
// Description : Self-checking bench for proc_gain_ctrl with a sample scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_gain_ctrl;

    localparam int         CLK_DIV = 8;
    localparam logic [9:0] ADC_OFF = 10'h181;
    localparam logic [9:0] DAC_OFF = 10'h200;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [9:0] data_in  = 10'h201;
    logic [1:0] gain_sel = 2'd0;
    logic       mute     = 1'b1;
    logic [9:0] data_out;
    logic       sample_tick;
    logic       busy;

    int checks = 0;
    int errors = 0;

    proc_gain_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .ADC_OFFSET (ADC_OFF),
        .DAC_OFFSET (DAC_OFF)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .gain_sel    (gain_sel),
        .mute        (mute),
        .data_out    (data_out),
        .sample_tick (sample_tick),
        .busy        (busy)
    );

    always #5 sysclk = ~sysclk;

    // ---------------- reference model + scoreboard ----------------
    int          m_cnt, m_level, m_gain, m_state;   // state: 0 muted,1 up,2 run,3 down
    logic [9:0]  exp_q[$];

    function automatic logic [9:0] model_out(input logic [9:0] d, input int g, input int lvl);
        logic signed [9:0] x;
        int xi, gv, s;
        x  = d - ADC_OFF;
        xi = int'(x);
        gv = xi * (1 << g);
        if (gv > 511)  gv = 511;
        if (gv < -512) gv = -512;
        s = (gv * lvl) >>> 4;
        return 10'(s + 512);
    endfunction

    always @(posedge sysclk or negedge rst_n) begin
        bit tk, chg;
        if (!rst_n) begin
            m_cnt = 0; m_level = 0; m_gain = 0; m_state = 0;
            exp_q.delete();
        end else begin
            tk  = (m_cnt == CLK_DIV - 1);
            chg = mute || (int'(gain_sel) != m_gain);
            if (tk) exp_q.push_back(model_out(data_in, m_gain, m_level));
            case (m_state)
                0: if (!mute) begin m_gain = int'(gain_sel); m_state = 1; end
                1: begin
                    if (tk) m_level++;
                    if (chg) m_state = 3;
                    else if (m_level == 16) m_state = 2;
                end
                2: if (chg) m_state = 3;
                default: begin
                    if (m_level == 0) m_state = 0;
                    else if (tk) begin
                        m_level--;
                        if (m_level == 0) m_state = 0;
                    end
                end
            endcase
            m_cnt = tk ? 0 : m_cnt + 1;
        end
    end

    always @(negedge sysclk) begin
        logic [9:0] e;
        bit etk, ebusy;
        etk   = rst_n && (m_cnt == CLK_DIV - 1);
        ebusy = rst_n && (m_state == 1 || m_state == 3);
        checks++;
        if (sample_tick !== etk) begin
            errors++;
            $display("FAIL sb_tick @%0t: got %b want %b", $time, sample_tick, etk);
        end
        checks++;
        if (busy !== ebusy) begin
            errors++;
            $display("FAIL sb_busy @%0t: got %b want %b", $time, busy, ebusy);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (data_out !== e) begin
                errors++;
                $display("FAIL sb_data @%0t: got %h want %h", $time, data_out, e);
            end
        end
    end

    // Returns 1ns after the edge that ends the next tick cycle.
    task automatic after_tick();
        bit seen = 0;
        for (int i = 0; i < 2 * CLK_DIV + 2 && !seen; i++) begin
            @(negedge sysclk);
            if (sample_tick === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL tick_timeout @%0t: got no tick want tick", $time);
        end
        @(posedge sysclk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0; mute = 1'b1; data_in = 10'h201; gain_sel = 2'd0;
        repeat (3) @(negedge sysclk);
        checks++;
        if (data_out !== 10'h200 || busy !== 1'b0 || sample_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%b want 200/0/0", data_out, busy, sample_tick);
        end
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge sysclk); #1; n++; end while (sample_tick !== 1'b1 && n < 4 * CLK_DIV);
        checks++;
        if (n !== CLK_DIV - 1) begin
            errors++;
            $display("FAIL first_tick: got %0d edges want %0d", n, CLK_DIV - 1);
        end
        @(posedge sysclk); #1;
        checks++;
        if (sample_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: got %b want 0", sample_tick);
        end
        n = 1;
        while (sample_tick !== 1'b1 && n < 4 * CLK_DIV) begin @(posedge sysclk); #1; n++; end
        checks++;
        if (n !== CLK_DIV) begin
            errors++;
            $display("FAIL tick_period: got %0d want %0d", n, CLK_DIV);
        end
        for (int i = 0; i < 20; i++) begin
            after_tick();
            checks++;
            if (data_out !== 10'h200 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mute_hold[%0d]: got %h/%b want 200/0", i, data_out, busy);
            end
        end
    endtask

    task automatic test_ramp_up();
        mute = 1'b0; gain_sel = 2'd0; data_in = 10'h201;
        for (int k = 1; k <= 20; k++) begin
            after_tick();
            if (k == 1 || k == 9 || k >= 17) begin
                logic [9:0] want;
                want = (k == 1) ? 10'h200 : (k == 9) ? 10'h240 : 10'h280;
                checks++;
                if (data_out !== want) begin
                    errors++;
                    $display("FAIL ramp_up_data[%0d]: got %h want %h", k, data_out, want);
                end
            end
            if (k == 15 || k == 16) begin
                checks++;
                if (busy !== (k == 15)) begin
                    errors++;
                    $display("FAIL ramp_up_busy[%0d]: got %b want %b", k, busy, k == 15);
                end
            end
        end
    endtask

    task automatic test_saturation();
        gain_sel = 2'd3;
        for (int k = 0; k < 33; k++) after_tick();
        checks++;
        if (data_out !== 10'h3FF) begin
            errors++;
            $display("FAIL sat_pos: got %h want 3ff", data_out);
        end
        data_in = 10'h101;
        after_tick();
        checks++;
        if (data_out !== 10'h000) begin
            errors++;
            $display("FAIL sat_neg: got %h want 000", data_out);
        end
        data_in = 10'h180; gain_sel = 2'd0;
        for (int k = 0; k < 18; k++) after_tick();
        checks++;
        if (data_out !== 10'h1FF) begin
            errors++;
            $display("FAIL floor_neg1: got %h want 1ff", data_out);
        end
        for (int k = 0; k < 15; k++) after_tick();
    endtask

    task automatic test_interrupt();
        mute = 1'b1;
        for (int k = 0; k < 16; k++) after_tick();
        mute = 1'b0; data_in = 10'h201;
        for (int k = 0; k < 5; k++) after_tick();
        gain_sel = 2'd1;
        for (int k = 1; k <= 5; k++) begin
            after_tick();
            checks++;
            if (busy !== (k < 5)) begin
                errors++;
                $display("FAIL intr_busy[%0d]: got %b want %b", k, busy, k < 5);
            end
        end
        @(posedge sysclk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL intr_reup: got %b want 1", busy);
        end
        for (int k = 0; k < 17; k++) after_tick();
        checks++;
        if (data_out !== 10'h300) begin
            errors++;
            $display("FAIL intr_gain2: got %h want 300", data_out);
        end
    endtask

    task automatic test_async_reset();
        int n;
        mute = 1'b1;
        for (int k = 0; k < 16; k++) after_tick();
        mute = 1'b0;
        for (int k = 0; k < 9; k++) after_tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 10'h200 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b want 200/0", data_out, busy);
        end
        mute = 1'b1;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge sysclk); #1; n++; end while (sample_tick !== 1'b1 && n < 4 * CLK_DIV);
        checks++;
        if (n !== CLK_DIV - 1) begin
            errors++;
            $display("FAIL async_first_tick: got %0d edges want %0d", n, CLK_DIV - 1);
        end
    endtask

    task automatic test_offset_wrap();
        after_tick();
        mute = 1'b0; gain_sel = 2'd0; data_in = 10'h3FF;
        for (int k = 0; k < 17; k++) after_tick();
        checks++;
        if (data_out !== 10'h07E) begin
            errors++;
            $display("FAIL offset_wrap: got %h want 07e", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_saturation();
        test_interrupt();
        test_async_reset();
        test_offset_wrap();
        repeat (2) @(negedge sysclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_gain_ctrl.md
Name: proc_gain_ctrl

Overview:
Sample-rate sequencer and gain/mute controller for the ADC→DAC audio processing path. It derives a periodic sample strobe from sysclk, captures and offset-corrects ADC samples, and applies a selectable power-of-two gain with saturation. A 16-step soft ramp is applied on unmute, mute and gain change, so level changes are click-free. The output feeds the DAC directly.

Parameters:
CLK_DIV, 5000, sysclk cycles per sample period (must be ≥ 2).
ADC_OFFSET, 10'h181, ADC mid-scale subtracted from the input.
DAC_OFFSET, 10'h200, DAC mid-scale added to the output.

Ports:
sysclk  in  1  system clock; all state changes on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
data_in  in  10  raw unsigned ADC sample.
gain_sel  in  2  gain code: 0 = x1, 1 = x2, 2 = x4, 3 = x8.
mute  in  1  1 requests a ramp to silence.
data_out  out  10  unsigned DAC sample, registered.
sample_tick  out  1  one-cycle strobe marking each sample period.
busy  out  1  high while a ramp is in progress.

Behaviour:
- Reset (asynchronous, immediate, takes effect even mid-ramp):
  - data_out = DAC_OFFSET; sample_tick = 0; busy = 0.
  - Divider counter = 0; level = 0; cur_gain = 0; state = MUTED.
- Divider: the counter runs 0..CLK_DIV-1 and wraps. sample_tick = 1 exactly when the counter = CLK_DIV-1.
  - After reset release, the first tick is the CLK_DIV-th cycle.
  - The period is exactly CLK_DIV cycles.
- Datapath, evaluated in each tick cycle:
  - x = data_in - ADC_OFFSET, 10-bit two's complement, wraps modulo 1024.
  - g = x << cur_gain, computed wide and then saturated to [-512, 511].
  - s = (g * level) >>> 4: signed, arithmetic shift (floor), level in 0..16.
  - data_out <= s + DAC_OFFSET, modulo 1024, captured on the edge that ends the tick cycle.
  - data_out holds its value between ticks.
- The sample in a tick cycle uses the level value before that tick's level update.
- FSM: states are evaluated every cycle; level changes only in tick cycles.
  - MUTED: level = 0. If mute = 0, load cur_gain <= gain_sel and go to RAMP_UP.
  - RAMP_UP: each tick, level += 1. When level becomes 16, go to RUN. If mute = 1 or gain_sel ≠ cur_gain, go to RAMP_DOWN; level continues from its current value.
  - RUN: level = 16. If mute = 1 or gain_sel ≠ cur_gain, go to RAMP_DOWN.
  - RAMP_DOWN: each tick, level -= 1. When level becomes 0, go to MUTED. Changes to mute and gain_sel are ignored in this state.
  - Gain is reloaded only in MUTED, which re-evaluates on the very next cycle.
- busy = 1 in RAMP_UP and RAMP_DOWN, decoded from the registered state.
- Simultaneous events:
  - A mute or gain change in the same cycle as the tick that completes RAMP_UP: level still becomes 16, but the state goes to RAMP_DOWN, not RUN.
  - A tick arriving while the state leaves MUTED: level stays 0 for that tick.
- Ramp timing: 16 ticks from MUTED to full level and 16 ticks from full level back to 0. A ramp that is interrupted is symmetric about the level reached when it was interrupted.

Test Plan:
1. Reset and mute hold: hold rst_n = 0, then release with mute = 1, data_in = 0x201 → data_out = 0x200 for 20 ticks, busy = 0; sample_tick pulses one cycle wide every CLK_DIV cycles (bench CLK_DIV = 8).
2. Ramp up: mute = 0, gain_sel = 0, data_in = 0x201 (x = 128).
   - First sample 0x200; sample at level 8 = 0x240.
   - busy falls after the 16th tick; every later sample = 0x280.
3. Saturation: in RUN, set gain_sel = 3 → ramp down over 16 ticks, reload gain, ramp up.
   - With data_in = 0x201: final data_out = 0x3FF.
   - With data_in = 0x101 (x = -128): final data_out = 0x000.
   - With data_in = 0x180 (x = -1), level 1, gain x1: data_out = 0x1FF.
4. Interrupted ramp: change gain_sel when level = 5 in RAMP_UP → exactly 5 ticks of RAMP_DOWN, MUTED for 1 cycle, then RAMP_UP with the new cur_gain; busy stays high except for that 1 cycle.
5. Async reset mid-ramp: assert rst_n = 0 between clock edges at level 9 → data_out = 0x200 and busy = 0 immediately; after release, the next tick arrives CLK_DIV cycles later.
6. Offset wrap: data_in = 0x3FF, gain x1, RUN → x = -386 (wrapped), data_out = 0x07E.
